// File: rtl/duty_clk_ctrl.sv
// rtl/duty_clk_ctrl.sv - programmable low-then-high duty-cycle waveform generator
// Config handshake with shadow registers; start, stop and config changes land on period boundaries.
module duty_clk_ctrl #(
    parameter int CW         = 8,
    parameter int DEF_PERIOD = 40,
    parameter int DEF_HIGH   = 10
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          enable_i,
    input  logic          cfg_valid_i,
    output logic          cfg_ready_o,
    input  logic [CW-1:0] cfg_period_i,
    input  logic [CW-1:0] cfg_high_i,
    output logic          cfg_err_o,
    output logic          wave_out_o,
    output logic          period_start_o,
    output logic          busy_o
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CW-1:0] DEF_P = CW'(DEF_PERIOD);
    localparam logic [CW-1:0] DEF_H = CW'(DEF_HIGH);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] act_period_q, act_period_d;
    logic [CW-1:0] act_high_q, act_high_d;
    logic [CW-1:0] shadow_period_q, shadow_period_d;
    logic [CW-1:0] shadow_high_q, shadow_high_d;
    logic          pending_q, pending_d;
    logic          wave_q, wave_d;
    logic          cfg_err_q, cfg_err_d;

    logic xfer;
    logic cfg_ok;
    logic boundary;

    always_comb begin
        xfer     = cfg_valid_i && !pending_q;
        cfg_ok   = (cfg_period_i >= CW'(2)) && (cfg_high_i != '0) && (cfg_high_i < cfg_period_i);
        boundary = (state_q == RUN) && (cnt_q == act_period_q - CW'(1));

        state_d         = state_q;
        cnt_d           = cnt_q;
        act_period_d    = act_period_q;
        act_high_d      = act_high_q;
        shadow_period_d = shadow_period_q;
        shadow_high_d   = shadow_high_q;
        pending_d       = pending_q;
        cfg_err_d       = xfer && !cfg_ok;

        case (state_q)
            IDLE: begin
                if (xfer && cfg_ok) begin
                    act_period_d = cfg_period_i;
                    act_high_d   = cfg_high_i;
                end
                if (enable_i) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (boundary) begin
                    cnt_d = '0;
                    // xfer implies !pending, so the two loads never collide
                    if (pending_q) begin
                        act_period_d = shadow_period_q;
                        act_high_d   = shadow_high_q;
                        pending_d    = 1'b0;
                    end else if (xfer && cfg_ok) begin
                        act_period_d = cfg_period_i;
                        act_high_d   = cfg_high_i;
                    end
                    if (!enable_i) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (xfer && cfg_ok) begin
                        shadow_period_d = cfg_period_i;
                        shadow_high_d   = cfg_high_i;
                        pending_d       = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Decode from next state so the output pin comes straight from a flop
        wave_d = (state_d == RUN) && (cnt_d >= act_period_d - act_high_d);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            act_period_q    <= DEF_P;
            act_high_q      <= DEF_H;
            shadow_period_q <= DEF_P;
            shadow_high_q   <= DEF_H;
            pending_q       <= 1'b0;
            wave_q          <= 1'b0;
            cfg_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            act_period_q    <= act_period_d;
            act_high_q      <= act_high_d;
            shadow_period_q <= shadow_period_d;
            shadow_high_q   <= shadow_high_d;
            pending_q       <= pending_d;
            wave_q          <= wave_d;
            cfg_err_q       <= cfg_err_d;
        end
    end

    assign wave_out_o     = wave_q;
    assign period_start_o = (state_q == RUN) && (cnt_q == '0);
    assign busy_o         = (state_q == RUN);
    assign cfg_ready_o    = !pending_q;
    assign cfg_err_o      = cfg_err_q;

endmodule

// File: tb/tb_duty_clk_ctrl.sv
// tb/tb_duty_clk_ctrl.sv - self-checking bench for duty_clk_ctrl
module tb_duty_clk_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       cv;
    logic [7:0] cp;
    logic [7:0] ch;
    logic       rdy, err, wave, ps, busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic       cv;
        logic [7:0] cp;
        logic [7:0] ch;
        logic       e_wave;
        logic       e_ps;
        logic       e_busy;
        logic       e_rdy;
        logic       e_err;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    duty_clk_ctrl #(.CW(8), .DEF_PERIOD(40), .DEF_HIGH(10)) dut (
        .clock_i        (clk),
        .reset_i        (rst),
        .enable_i       (en),
        .cfg_valid_i    (cv),
        .cfg_ready_o    (rdy),
        .cfg_period_i   (cp),
        .cfg_high_i     (ch),
        .cfg_err_o      (err),
        .wave_out_o     (wave),
        .period_start_o (ps),
        .busy_o         (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_cycle(input int p, input int h, input int c, input int r);
        chk($sformatf("wave P%0d H%0d c%0d", p, h, c), int'(wave), (c >= p - h) ? 1 : 0);
        chk($sformatf("period_start P%0d c%0d", p, c), int'(ps), (c == 0) ? 1 : 0);
        chk($sformatf("busy P%0d c%0d", p, c), int'(busy), 1);
        chk($sformatf("cfg_ready P%0d c%0d", p, c), int'(rdy), r);
        chk($sformatf("cfg_err P%0d c%0d", p, c), int'(err), 0);
    endtask

    task automatic run_cycles(input int p, input int h, input int from, input int to, input int r);
        for (int c = from; c <= to; c++) begin
            step();
            check_cycle(p, h, c, r);
        end
    endtask

    task automatic check_idle(input string name);
        chk({name, " wave"}, int'(wave), 0);
        chk({name, " period_start"}, int'(ps), 0);
        chk({name, " busy"}, int'(busy), 0);
        chk({name, " cfg_ready"}, int'(rdy), 1);
    endtask

    task automatic cfg_pulse(input int p, input int h);
        cv = 1'b1;
        cp = 8'(p);
        ch = 8'(h);
        step();
        cv = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cv = 1'b0; cp = '0; ch = '0;

        //         rst   en    cv    cp     ch     wave  ps    busy  rdy   err
        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'd0,  8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 8'd0,  8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 8'd1,  8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 8'd0,  8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 8'd5,  8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 8'd10, 8'd10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 8'd0,  8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 8'd1,  8'd1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        for (int i = 0; i < 8; i++) begin
            rst = vecs[i].rst; en = vecs[i].en; cv = vecs[i].cv;
            cp  = vecs[i].cp;  ch = vecs[i].ch;
            step();
            chk($sformatf("vec%0d wave", i), int'(wave), int'(vecs[i].e_wave));
            chk($sformatf("vec%0d period_start", i), int'(ps), int'(vecs[i].e_ps));
            chk($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].e_busy));
            chk($sformatf("vec%0d cfg_ready", i), int'(rdy), int'(vecs[i].e_rdy));
            chk($sformatf("vec%0d cfg_err", i), int'(err), int'(vecs[i].e_err));
        end
        cv = 1'b0;

        // defaults (invalid configs must not have touched them), two full periods
        en = 1'b1;
        run_cycles(40, 10, 0, 39, 1);
        run_cycles(40, 10, 0, 39, 1);

        // graceful stop: enable dropped at cnt=5 runs through cnt=39
        run_cycles(40, 10, 0, 5, 1);
        en = 1'b0;
        run_cycles(40, 10, 6, 39, 1);
        step();
        check_idle("after stop");

        // idle config 8/2, then enable
        cfg_pulse(8, 2);
        check_idle("idle cfg");
        chk("idle cfg err", int'(err), 0);
        en = 1'b1;
        for (int k = 0; k < 3; k++) run_cycles(8, 2, 0, 7, 1);

        // boundary config 40/10 applies immediately
        cfg_pulse(40, 10);
        check_cycle(40, 10, 0, 1);
        run_cycles(40, 10, 1, 39, 1);

        // boundary config at cnt=39: 16/4 next period, ready stays high
        cfg_pulse(16, 4);
        check_cycle(16, 4, 0, 1);
        run_cycles(16, 4, 1, 15, 1);

        // mid-period config back to 40/10 is shadowed
        run_cycles(16, 4, 0, 5, 1);
        cfg_pulse(40, 10);
        check_cycle(16, 4, 6, 0);
        run_cycles(16, 4, 7, 15, 0);

        // 20/5 requested at cnt=12 of a 40/10 period
        run_cycles(40, 10, 0, 12, 1);
        cfg_pulse(20, 5);
        check_cycle(40, 10, 13, 0);
        run_cycles(40, 10, 14, 39, 0);
        run_cycles(20, 5, 0, 19, 1);
        run_cycles(20, 5, 0, 19, 1);

        // reset at cnt=35 with a pending 8/2 config
        cfg_pulse(40, 10);
        check_cycle(40, 10, 0, 1);
        run_cycles(40, 10, 1, 20, 1);
        cfg_pulse(8, 2);
        check_cycle(40, 10, 21, 0);
        run_cycles(40, 10, 22, 35, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("after reset");
        chk("after reset cfg_err", int'(err), 0);
        run_cycles(40, 10, 0, 39, 1);
        run_cycles(40, 10, 0, 39, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/duty_clk_ctrl.md
Name: duty_clk_ctrl

Overview:
- Synthesizable, programmable duty-cycle waveform controller; replaces the behavioural delay-based clock generator in our RTL.
- Counts system clock cycles to produce a low-then-high periodic waveform with run-time configurable period and high time.
- Defaults to period 40, high 10 (25% duty, starts low).
- Provides a config handshake, graceful start/stop at period boundaries and a period-start strobe for downstream sequencing.

Parameters:
- CW, 8, width of period/high counters and config fields.
- DEF_PERIOD, 40, reset period in clock cycles.
- DEF_HIGH, 10, reset high-phase length in clock cycles.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request; sampled at start and at period boundaries only.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  controller can accept a config.
- cfg_period  in  CW  requested period (cycles).
- cfg_high  in  CW  requested high-phase length (cycles).
- cfg_err  out  1  one-cycle pulse: last accepted config was invalid.
- wave_out  out  1  generated waveform, registered.
- period_start  out  1  high in the first cycle (cnt==0) of every running period.
- busy  out  1  waveform running.

Behaviour:
- State: run (IDLE/RUN), cnt[CW], act_period, act_high, shadow_period, shadow_high, pending.
- Reset (sync, priority over all): run=0, cnt=0, act=DEF_PERIOD/DEF_HIGH, pending=0. Outputs next cycle: wave_out=0, period_start=0, busy=0, cfg_err=0, cfg_ready=1.
- Output decode from registered state, no combinational path from inputs:
  - wave_out = run && (cnt >= act_period-act_high); implemented so the pin is driven from a flop.
  - period_start = run && cnt==0.
  - busy = run.
  - cfg_ready = !pending.
- Waveform shape: low for P-H cycles, then high for H cycles, every P cycles.
- Start: IDLE with enable=1 -> next cycle run=1, cnt=0. Start latency is 1 cycle.
- Count: while run, cnt increments each cycle. The cycle with cnt==act_period-1 is the boundary; next cnt=0.
- Boundary actions, all in the same cycle:
  - if pending, load shadow into act and clear pending;
  - if enable==0, go to IDLE (cnt=0, wave_out 0 next cycle).
  - Otherwise the next period starts with cnt=0.
- Stop is graceful: enable deasserted mid-period has no effect until the boundary. Re-asserting it before the boundary cancels the stop.
- Config validity: 2 <= cfg_period, and 1 <= cfg_high <= cfg_period-1.
- Config handshake: a transfer occurs when cfg_valid && cfg_ready.
  - Invalid config: consumed, cfg_err=1 for one cycle, no state change.
  - Valid, IDLE: written to act next cycle. If enable=1 in the same cycle, the first period uses the new config.
  - Valid, RUN, boundary cycle: bypasses shadow and applies to the period starting next cycle. pending stays 0.
  - Valid, RUN, non-boundary: written to shadow, pending=1, cfg_ready=0 until the boundary. Back to 1 in the cycle cnt==0.
- Reset mid-operation: discards pending config and any running period. Waveform low the cycle after reset.

Test Plan:
- Reset, then enable=1 held, defaults -> busy 1 cycle after enable. wave_out low 30 cycles, high 10, repeating. period_start pulses every 40 cycles.
- IDLE, cfg 8/2 accepted, then enable=1 -> waveform 6 low / 2 high, period 8. cfg_err stays 0.
- Running 40/10, cfg 20/5 at cnt=12 -> cfg_ready 0 from the next cycle. Current period completes 40 cycles. Next periods are 15 low / 5 high. cfg_ready returns 1 at cnt==0.
- Cfg at the boundary cycle (cnt==39) with 16/4 -> the immediately following period is 12 low / 4 high. cfg_ready never drops.
- Invalid cfgs (period=1; high=0; high=period=10) -> cfg_err one-cycle pulse each, act unchanged, waveform still 30/10.
- enable dropped at cnt=5, and separately reset asserted at cnt=35:
  - enable drop -> runs to cnt=39, then busy 0, wave_out 0.
  - reset -> next cycle wave_out 0, busy 0. Restart gives 30/10 with any pending config discarded.
